// File: rtl/panel_pkg.sv
// Shared types and constants for the front-panel I/O path.
// PANEL_OCTAL_EN selects 3-bit octal digits instead of 4-bit hex digits.
package panel_pkg;

`ifdef PANEL_OCTAL_EN
  localparam int unsigned DIGIT_W = 3;
`else
  localparam int unsigned DIGIT_W = 4;
`endif

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_BLANK = 7'h7F;

  // Active-low {g,f,e,d,c,b,a}, indexed by digit value 0..F
  localparam seg_t SEG_LUT [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  function automatic seg_t seg_decode(input logic [3:0] v);
    return SEG_LUT[v];
  endfunction

endpackage

// File: rtl/panel_io_if.sv
// Board-side display and button signals of the front panel.
// master = controller/board side, slave = panel_io.
interface panel_io_if #(
  parameter int unsigned NUM_DIGITS = 8,
  parameter int unsigned NUM_BTNS   = 5
);
  import panel_pkg::*;

  logic [DIGIT_W*NUM_DIGITS-1:0] digit_value;
  logic [NUM_DIGITS-1:0]         digit_en;
  logic [NUM_DIGITS-1:0]         dp_in;
  logic [NUM_BTNS-1:0]           btn_raw;
  logic [NUM_BTNS-1:0]           btn_level;
  logic [NUM_BTNS-1:0]           btn_press;
  logic [NUM_DIGITS-1:0]         an;
  seg_t                          seg;
  logic                          dp;

  modport master (
    output digit_value, digit_en, dp_in, btn_raw,
    input  btn_level, btn_press, an, seg, dp
  );

  modport slave (
    input  digit_value, digit_en, dp_in, btn_raw,
    output btn_level, btn_press, an, seg, dp
  );

endinterface

// File: rtl/panel_debounce.sv
// Single-button debouncer: two-flop synchroniser, stability counter,
// accepted level and a one-clock pulse on each accepted rising edge.
module panel_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic press
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // Any cycle where the synchronised input matches the level restarts the count
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt   <= '0;
      level <= 1'b0;
      press <= 1'b0;
    end else begin
      press <= 1'b0;
      if (sync2 != level) begin
        if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
          cnt   <= '0;
          level <= sync2;
          press <= sync2;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/panel_io.sv
// Front-panel I/O: multiplexed seven-segment scan plus per-button debounce.
// Build with PANEL_OCTAL_EN for 3-bit octal digits (see panel_pkg).
module panel_io
  import panel_pkg::*;
#(
  parameter int unsigned NUM_DIGITS      = 8,
  parameter int unsigned NUM_BTNS        = 5,
  parameter int unsigned SCAN_DIV        = 100000,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic       clock,
  input  logic       reset,
  panel_io_if.slave  pio
);

  localparam int unsigned CW = $clog2(SCAN_DIV);
  localparam int unsigned IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic [CW-1:0]         scan_cnt;
  logic [IW-1:0]         idx;
  logic [DIGIT_W-1:0]    cur_val;
  logic [NUM_DIGITS-1:0] an_next;
  seg_t                  seg_next;
  logic                  dp_next;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      scan_cnt <= '0;
      idx      <= '0;
    end else if (scan_cnt == CW'(SCAN_DIV - 1)) begin
      scan_cnt <= '0;
      idx      <= (idx == IW'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;
    end else begin
      scan_cnt <= scan_cnt + 1'b1;
    end
  end

  always_comb begin
    cur_val  = pio.digit_value[DIGIT_W*int'(idx) +: DIGIT_W];
    an_next  = ~(NUM_DIGITS'(1) << idx);
    seg_next = SEG_BLANK;
    dp_next  = 1'b1;
    // Blanked digits keep their anode slot so frame timing never changes
    if (pio.digit_en[idx]) begin
      seg_next = seg_decode(4'(cur_val));
      dp_next  = ~pio.dp_in[idx];
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pio.an  <= '1;
      pio.seg <= SEG_BLANK;
      pio.dp  <= 1'b1;
    end else begin
      pio.an  <= an_next;
      pio.seg <= seg_next;
      pio.dp  <= dp_next;
    end
  end

  for (genvar b = 0; b < NUM_BTNS; b++) begin : g_btn
    panel_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
      .clock (clock),
      .reset (reset),
      .raw   (pio.btn_raw[b]),
      .level (pio.btn_level[b]),
      .press (pio.btn_press[b])
    );
  end

endmodule

// File: tb/tb_panel_io.sv
// Self-checking bench for panel_io: directed scan/blank/debounce/reset cases
// followed by randomized traffic against a behavioural reference model.
module tb_panel_io;

  localparam int unsigned ND  = 4;
  localparam int unsigned NB  = 5;
  localparam int unsigned SD  = 3;
  localparam int unsigned DEB = 4;
`ifdef PANEL_OCTAL_EN
  localparam int unsigned DW = 3;
`else
  localparam int unsigned DW = 4;
`endif

  logic clock = 1'b0;
  logic reset;

  always #5 clock = ~clock;

  panel_io_if #(.NUM_DIGITS(ND), .NUM_BTNS(NB)) pio ();

  panel_io #(
    .NUM_DIGITS      (ND),
    .NUM_BTNS        (NB),
    .SCAN_DIV        (SD),
    .DEBOUNCE_CYCLES (DEB)
  ) dut (
    .clock (clock),
    .reset (reset),
    .pio   (pio)
  );

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [6:0] ref_seg(input int unsigned v);
    case (v)
      0:  return 7'h40;  1:  return 7'h79;  2:  return 7'h24;  3:  return 7'h30;
      4:  return 7'h19;  5:  return 7'h12;  6:  return 7'h02;  7:  return 7'h78;
      8:  return 7'h00;  9:  return 7'h10;  10: return 7'h08;  11: return 7'h03;
      12: return 7'h46;  13: return 7'h21;  14: return 7'h06;  default: return 7'h0E;
    endcase
  endfunction

  // Reference model state: edges since reset, raw history, accepted levels
  int unsigned     t;
  logic [NB-1:0]   hist1, hist2;
  logic [NB-1:0]   lvl, prs;
  int unsigned     run [NB];
  logic [ND-1:0]   exp_an;
  logic [6:0]      exp_seg;
  logic            exp_dp;

  task automatic model_reset();
    t = 0; hist1 = '0; hist2 = '0; lvl = '0; prs = '0;
    for (int b = 0; b < NB; b++) run[b] = 0;
  endtask

  // A button change is accepted once the raw value seen two edges earlier
  // has disagreed with the accepted level on DEB consecutive edges.
  task automatic model_edge();
    int unsigned dig, val;
    logic        d;
    t++;
    prs = '0;
    for (int b = 0; b < NB; b++) begin
      d = hist2[b];
      if (d != lvl[b]) begin
        run[b]++;
        if (run[b] == DEB) begin
          lvl[b] = d; run[b] = 0; prs[b] = d;
        end
      end else begin
        run[b] = 0;
      end
    end
    hist2 = hist1;
    hist1 = pio.btn_raw;
    dig = ((t - 1) / SD) % ND;
    val = int'(pio.digit_value >> (DW * dig)) & ((1 << DW) - 1);
    exp_an = ~(ND'(1) << dig);
    if (pio.digit_en[dig]) begin
      exp_seg = ref_seg(val);
      exp_dp  = ~pio.dp_in[dig];
    end else begin
      exp_seg = 7'h7F;
      exp_dp  = 1'b1;
    end
  endtask

  task automatic tick();
    @(posedge clock);
    model_edge();
    #1;
    check("an", pio.an, exp_an);
    check("seg", pio.seg, exp_seg);
    check("dp", pio.dp, exp_dp);
    check("btn_level", pio.btn_level, lvl);
    check("btn_press", pio.btn_press, prs);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_an"}, pio.an, {ND{1'b1}});
    check({tag, "_seg"}, pio.seg, 7'h7F);
    check({tag, "_dp"}, pio.dp, 1'b1);
    check({tag, "_level"}, pio.btn_level, '0);
    check({tag, "_press"}, pio.btn_press, '0);
  endtask

  // Asserts reset asynchronously between edges, then releases on a falling edge
  task automatic do_reset();
    #2 reset = 1'b1;
    #1 check_reset_vals("async_rst");
    model_reset();
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  logic [DW*ND-1:0] dv;
  int unsigned      first_rise, n_press;

  initial begin
    reset           = 1'b1;
    pio.digit_value = '0;
    pio.digit_en    = '1;
    pio.dp_in       = '0;
    pio.btn_raw     = '0;
    model_reset();
    #1 check_reset_vals("por");
    @(negedge clock);
    reset = 1'b0;

    // Scan: two full frames of a fixed pattern
`ifdef PANEL_OCTAL_EN
    pio.digit_value = 12'o7654;
`else
    pio.digit_value = 16'h1234;
`endif
    for (int i = 0; i < 2 * ND * SD + 1; i++) tick();

    // Blanking and decimal point
    for (int i = 0; i < ND; i++) dv[DW*i +: DW] = DW'((DW == 4) ? 8 : 5);
    pio.digit_value = dv;
    pio.digit_en    = 4'b1101;
    pio.dp_in       = 4'b0001;
    for (int i = 0; i < ND * SD + 2; i++) tick();

    // Press latency and single pulse on button 2
    pio.btn_raw[2] = 1'b1;
    first_rise = 0; n_press = 0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (pio.btn_level[2] && first_rise == 0) first_rise = k;
      if (pio.btn_press[2]) n_press++;
    end
    check("press_latency", first_rise, DEB + 2);
    check("press_count", n_press, 1);

    // Release: level falls after the same delay, no pulse
    pio.btn_raw[2] = 1'b0;
    first_rise = 0; n_press = 0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (!pio.btn_level[2] && first_rise == 0) first_rise = k;
      if (pio.btn_press != '0) n_press++;
    end
    check("release_latency", first_rise, DEB + 2);
    check("release_pulses", n_press, 0);

    // Bounce on button 0 shorter than the debounce window
    n_press = 0;
    for (int i = 0; i < 8; i++) begin
      pio.btn_raw[0] = (i % 2 == 0);
      tick(); if (pio.btn_press[0] || pio.btn_level[0]) n_press++;
      tick(); if (pio.btn_press[0] || pio.btn_level[0]) n_press++;
    end
    pio.btn_raw[0] = 1'b0;
    check("bounce_quiet", n_press, 0);
    for (int i = 0; i < 4; i++) tick();

    // Reset mid-digit with a button held; press must reappear after full delay
    pio.btn_raw[3] = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    tick();
    do_reset();
    first_rise = 0; n_press = 0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (pio.btn_press[3]) begin
        n_press++;
        if (first_rise == 0) first_rise = k;
      end
    end
    check("rst_press_latency", first_rise, DEB + 2);
    check("rst_press_count", n_press, 1);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      pio.digit_value = DW*ND'($urandom);
      if ($urandom_range(0, 3) == 0) pio.digit_en = ND'($urandom);
      if ($urandom_range(0, 3) == 0) pio.dp_in    = ND'($urandom);
      if ($urandom_range(0, 5) == 0) pio.btn_raw[$urandom_range(0, NB - 1)] ^= 1'b1;
      if ($urandom_range(0, 7) == 0) pio.btn_raw = NB'($urandom);
      if ($urandom_range(0, 199) == 0) do_reset();
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
